alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set operand/result width.
REQ-002 Parameter SEL_WIDTH, default 3, SHALL set ALU opcode width.
REQ-003 Parameter NUM_REQ, default 4, range 2-8, SHALL set the number of requesters.
REQ-004 Parameter ALU_LATENCY, default 0, legal values 0 or 1, SHALL equal the attached ALU's output-register depth.
REQ-005 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 i_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 i_req_valid  input  NUM_REQ  SHALL be the per-requester request-valid bits.
REQ-008 i_req_src_a / i_req_src_b  input  NUM_REQ*DATA_WIDTH  SHALL be packed operands, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 i_req_sel  input  NUM_REQ*SEL_WIDTH  SHALL be packed opcodes, same packing rule.
REQ-010 o_req_ready  output  NUM_REQ  SHALL be the one-hot-or-zero accept strobe per requester.
REQ-011 o_alu_src_a / o_alu_src_b  output  DATA_WIDTH  and o_alu_sel  output  SEL_WIDTH  SHALL drive the shared ALU from registers.
REQ-012 i_alu_result  input  DATA_WIDTH  SHALL be the shared ALU result.
REQ-013 o_rsp_valid  output  1, o_rsp_id  output  $clog2(NUM_REQ), o_rsp_data  output  DATA_WIDTH  SHALL form the response channel.
REQ-014 i_rsp_ready  input  1  SHALL be the response-channel consumer ready.
REQ-015 o_busy  output  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-016 FSM SHALL have states IDLE, EXEC, RESP.
REQ-017 In IDLE, grant SHALL go to the first k with i_req_valid[k]=1 searching from rr_ptr upward with wrap-around; o_req_ready[k] SHALL be high combinationally for that k only, all other bits low.
REQ-018 A request SHALL be accepted in the IDLE cycle where i_req_valid[k] and o_req_ready[k] are both high; on that edge operands/opcode are latched into the o_alu_* registers, the id is latched, rr_ptr becomes (k+1) mod NUM_REQ, state becomes EXEC.
REQ-019 o_req_ready SHALL be all-zero outside IDLE and in IDLE when no valid is set; rr_ptr SHALL hold when nothing is accepted.
REQ-020 EXEC SHALL last exactly 1+ALU_LATENCY cycles; on its final edge i_alu_result SHALL be captured into o_rsp_data and state becomes RESP.
REQ-021 In RESP, o_rsp_valid SHALL be high with o_rsp_id/o_rsp_data stable until the cycle i_rsp_ready=1; on that edge state returns to IDLE and o_rsp_valid drops.
REQ-022 Minimum issue-to-issue spacing SHALL be 3+ALU_LATENCY cycles; no new accept occurs in the RESP handshake cycle.
REQ-023 o_alu_* registers SHALL hold their last values outside the accept edge.
REQ-024 A requester deasserting i_req_valid before acceptance SHALL forfeit the grant with no state change.
REQ-025 Two or more simultaneous valids SHALL be served one per transaction in rotating order; no requester waits more than NUM_REQ-1 other transactions.

Reset
REQ-026 Asserting i_rst_n=0 SHALL immediately, regardless of clock, force state=IDLE, rr_ptr=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, o_alu_src_a=0, o_alu_src_b=0, o_alu_sel=0, o_busy=0.
REQ-027 Reset mid-EXEC or mid-RESP SHALL discard the in-flight transaction with no response issued.
REQ-028 First accept after reset release SHALL occur no earlier than the first rising edge with i_rst_n=1.

Verification
REQ-029 ALU_LATENCY=0, req0 valid a=5 b=3 sel=000, i_rsp_ready=1 -> o_req_ready[0]=1 cycle 0, o_rsp_valid=1 cycle 2 with id=0 data=8.
REQ-030 All four valid continuously, i_rsp_ready=1 -> grant order 0,1,2,3,0; id sequence matches; one accept every 3 cycles.
REQ-031 rr_ptr=3 after serving req2, valids on req1 and req3 -> req3 granted first, then req1 (wrap-around).
REQ-032 i_rsp_ready held 0 for 5 cycles in RESP -> o_rsp_valid, id, data stable, o_req_ready all-zero, then release returns to IDLE next edge.
REQ-033 ALU_LATENCY=1, req2 a=9 b=4 sel=001 -> EXEC 2 cycles, response id=2 data=5.
REQ-034 i_rst_n pulsed low during EXEC -> all outputs zero asynchronously, no response after release, next grant starts search at req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one ALU among NUM_REQ requesters.
// Accepts one request per transaction, waits for the ALU, then holds the response until it is taken.
module alu_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 3,
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_src_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_src_b,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]    i_req_sel,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [DATA_WIDTH-1:0]           o_alu_src_a,
  output logic [DATA_WIDTH-1:0]           o_alu_src_b,
  output logic [SEL_WIDTH-1:0]            o_alu_sel,
  input  logic [DATA_WIDTH-1:0]           i_alu_result,
  output logic                            o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]      o_rsp_id,
  output logic [DATA_WIDTH-1:0]           o_rsp_data,
  input  logic                            i_rsp_ready,
  output logic                            o_busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ID_W-1:0]         rr_ptr_r;
  logic [ID_W-1:0]         rr_nxt_s;
  logic                    exec_cnt_r;
  logic                    exec_last_s;
  logic                    grant_found_s;
  logic [ID_W-1:0]         grant_idx_s;
  logic                    accept_s;
  logic [NUM_REQ-1:0]      req_ready_s;
  logic [DATA_WIDTH-1:0]   sel_src_a_s;
  logic [DATA_WIDTH-1:0]   sel_src_b_s;
  logic [SEL_WIDTH-1:0]    sel_op_s;
  logic [DATA_WIDTH-1:0]   alu_src_a_r;
  logic [DATA_WIDTH-1:0]   alu_src_b_r;
  logic [SEL_WIDTH-1:0]    alu_sel_r;
  logic                    rsp_valid_r;
  logic [ID_W-1:0]         rsp_id_r;
  logic [DATA_WIDTH-1:0]   rsp_data_r;

  // Rotating priority search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx_v;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    idx_v         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_v = (int'(rr_ptr_r) + i) % NUM_REQ;
      if (!grant_found_s && i_req_valid[ID_W'(idx_v)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = ID_W'(idx_v);
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  assign accept_s    = (state_r == IDLE) && grant_found_s;
  assign rr_nxt_s    = ID_W'((int'(grant_idx_s) + 1) % NUM_REQ);
  assign exec_last_s = (ALU_LATENCY == 0) ? 1'b1 : exec_cnt_r;

  // Ready strobe is only ever raised for the granted requester while idle.
  always_comb begin
    req_ready_s = '0;
    if (accept_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_src_a_s = '0;
    sel_src_b_s = '0;
    sel_op_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx_s == ID_W'(k)) begin
        sel_src_a_s = i_req_src_a[k*DATA_WIDTH +: DATA_WIDTH];
        sel_src_b_s = i_req_src_b[k*DATA_WIDTH +: DATA_WIDTH];
        sel_op_s    = i_req_sel[k*SEL_WIDTH +: SEL_WIDTH];
      end else begin
        sel_src_a_s = sel_src_a_s;
        sel_src_b_s = sel_src_b_s;
        sel_op_s    = sel_op_s;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_found_s) state_nxt_s = EXEC;
        else               state_nxt_s = IDLE;
      end
      EXEC: begin
        if (exec_last_s) state_nxt_s = RESP;
        else             state_nxt_s = EXEC;
      end
      RESP: begin
        if (i_rsp_ready) state_nxt_s = IDLE;
        else             state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, pointer, ALU operand and response registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      exec_cnt_r  <= 1'b0;
      alu_src_a_r <= '0;
      alu_src_b_r <= '0;
      alu_sel_r   <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_data_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        rr_ptr_r    <= rr_nxt_s;
        alu_src_a_r <= sel_src_a_s;
        alu_src_b_r <= sel_src_b_s;
        alu_sel_r   <= sel_op_s;
        rsp_id_r    <= grant_idx_s;
        exec_cnt_r  <= 1'b0;
      end
      if (state_r == EXEC) begin
        if (exec_last_s) begin
          rsp_data_r  <= i_alu_result;
          rsp_valid_r <= 1'b1;
        end else begin
          exec_cnt_r  <= 1'b1;
        end
      end
      if ((state_r == RESP) && i_rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  assign o_req_ready = req_ready_s;
  assign o_alu_src_a = alu_src_a_r;
  assign o_alu_src_b = alu_src_b_r;
  assign o_alu_sel   = alu_sel_r;
  assign o_rsp_valid = rsp_valid_r;
  assign o_rsp_id    = rsp_id_r;
  assign o_rsp_data  = rsp_data_r;
  assign o_busy      = (state_r != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a zero-latency instance driven by a vector table and corner sequences,
// plus a one-cycle-latency instance for the registered-ALU case.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]   valid0, ready0;
  logic [127:0] a0, b0;
  logic [11:0]  sel0;
  logic [31:0]  alua0, alub0, result0, rspdata0;
  logic [2:0]   alusel0;
  logic         rspv0, rsprdy0, busy0;
  logic [1:0]   rspid0;

  logic [3:0]   valid1, ready1;
  logic [127:0] a1, b1;
  logic [11:0]  sel1;
  logic [31:0]  alua1, alub1, result1, rspdata1;
  logic [2:0]   alusel1;
  logic         rspv1, rsprdy1, busy1;
  logic [1:0]   rspid1;

  int checks;
  int failures;

  typedef struct { logic [1:0] id; logic [31:0] data; } rsp_t;
  rsp_t exp_q[$];

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    int          gid;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  function automatic logic [3:0] onehot(input int g);
    logic [3:0] v;
    v = 4'b0000;
    v[g[1:0]] = 1'b1;
    return v;
  endfunction

  alu_arbiter #(.DATA_WIDTH(32), .SEL_WIDTH(3), .NUM_REQ(4), .ALU_LATENCY(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid0), .i_req_src_a(a0), .i_req_src_b(b0),
    .i_req_sel(sel0), .o_req_ready(ready0), .o_alu_src_a(alua0), .o_alu_src_b(alub0),
    .o_alu_sel(alusel0), .i_alu_result(result0), .o_rsp_valid(rspv0), .o_rsp_id(rspid0),
    .o_rsp_data(rspdata0), .i_rsp_ready(rsprdy0), .o_busy(busy0));

  alu_arbiter #(.DATA_WIDTH(32), .SEL_WIDTH(3), .NUM_REQ(4), .ALU_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid1), .i_req_src_a(a1), .i_req_src_b(b1),
    .i_req_sel(sel1), .o_req_ready(ready1), .o_alu_src_a(alua1), .o_alu_src_b(alub1),
    .o_alu_sel(alusel1), .i_alu_result(result1), .o_rsp_valid(rspv1), .o_rsp_id(rspid1),
    .o_rsp_data(rspdata1), .i_rsp_ready(rsprdy1), .o_busy(busy1));

  // Shared ALUs: combinational for instance 0, one output register for instance 1.
  assign result0 = alu_f(alua0, alub0, alusel0);
  always @(posedge clk) result1 <= alu_f(alua1, alub1, alusel1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_ops0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    for (int k = 0; k < 4; k++) begin
      a0[k*32 +: 32] = a + 32'(k*16);
      b0[k*32 +: 32] = b;
      sel0[k*3 +: 3] = s;
    end
  endtask

  task automatic push_exp(input int gid, input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    exp_q.push_back('{2'(gid), alu_f(a + 32'(gid*16), b, s)});
  endtask

  task automatic pop_chk(input string name);
    rsp_t e;
    if (exp_q.size() == 0) begin
      chk({name, "_unexpected_rsp"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_id"}, 64'(rspid0), 64'(e.id));
      chk({name, "_data"}, 64'(rspdata0), 64'(e.data));
    end
  endtask

  // One full transaction on instance 0 with the consumer always ready.
  task automatic run_txn(input string name, input logic [3:0] mask, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] s, input int gid);
    int lat;
    @(negedge clk);
    valid0 = mask;
    set_ops0(a, b, s);
    #1;
    chk({name, "_grant"}, 64'(ready0), 64'(onehot(gid)));
    push_exp(gid, a, b, s);
    @(posedge clk);
    @(negedge clk);
    valid0 = 4'b0000;
    lat = 1;
    while (!rspv0 && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd2);
    pop_chk(name);
    @(posedge clk);
  endtask

  initial begin
    int n;
    int exp_seq[5];
    logic [31:0] exp_c;
    int lat;
    bit seen;

    checks = 0; failures = 0;
    rst_n = 1'b0; rsprdy0 = 1'b1; rsprdy1 = 1'b1;
    valid0 = 4'b0000; a0 = '0; b0 = '0; sel0 = '0;
    valid1 = 4'b0000; a1 = '0; b1 = '0; sel1 = '0;

    vecs[0] = '{4'b0001, 32'd5,          32'd3,          3'd0, 0};
    vecs[1] = '{4'b1111, 32'd100,        32'd7,          3'd1, 1};
    vecs[2] = '{4'b0101, 32'h0000_F0F0,  32'h0000_0FF0,  3'd2, 2};
    vecs[3] = '{4'b1010, 32'h0000_1234,  32'h0000_00FF,  3'd3, 3};
    vecs[4] = '{4'b1010, 32'hAAAA_5555,  32'hFFFF_0000,  3'd4, 1};
    vecs[5] = '{4'b0001, 32'hFFFF_FFFF,  32'd1,          3'd0, 0};
    vecs[6] = '{4'b1000, 32'd77,         32'd0,          3'd7, 3};

    #12;
    chk("rst_ready", 64'(ready0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_rsp_valid", 64'(rspv0), 64'd0);
    chk("rst_rsp_data", 64'(rspdata0), 64'd0);
    chk("rst_alu_a", 64'(alua0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].mask, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].gid);
    end

    // All four requesters held valid: rotating grants, one accept every 3 cycles.
    exp_seq = '{0, 1, 2, 3, 0};
    n = 0;
    set_ops0(32'd1000, 32'd1, 3'd0);
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      valid0 = (cyc <= 12) ? 4'hF : 4'h0;
      #1;
      if (ready0 != 4'b0000) begin
        if (n < 5) begin
          chk($sformatf("rot_grant%0d", n), 64'(ready0), 64'(onehot(exp_seq[n])));
          chk($sformatf("rot_cycle%0d", n), 64'(cyc), 64'(3*n));
          push_exp(exp_seq[n], 32'd1000, 32'd1, 3'd0);
        end else begin
          chk("rot_extra_grant", 64'(n), 64'd4);
        end
        n++;
      end
      if (rspv0) pop_chk("rot_rsp");
    end
    chk("rot_count", 64'(n), 64'd5);

    // Response stalled for 5 cycles: outputs must hold and no new grant may appear.
    @(negedge clk);
    rsprdy0 = 1'b0;
    valid0 = 4'b0100;
    set_ops0(32'h55, 32'h11, 3'd1);
    exp_c = alu_f(32'h55 + 32'd32, 32'h11, 3'd1);
    #1;
    chk("stall_grant", 64'(ready0), 64'(onehot(2)));
    push_exp(2, 32'h55, 32'h11, 3'd1);
    @(negedge clk);
    valid0 = 4'hF;
    #1;
    chk("stall_exec_ready", 64'(ready0), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall_valid%0d", i), 64'(rspv0), 64'd1);
      chk($sformatf("stall_id%0d", i), 64'(rspid0), 64'd2);
      chk($sformatf("stall_data%0d", i), 64'(rspdata0), 64'(exp_c));
      chk($sformatf("stall_ready%0d", i), 64'(ready0), 64'd0);
      @(negedge clk);
    end
    rsprdy0 = 1'b1;
    valid0 = 4'b0000;
    #1;
    pop_chk("stall_rsp");
    @(negedge clk);
    #1;
    chk("stall_release_valid", 64'(rspv0), 64'd0);
    chk("stall_release_busy", 64'(busy0), 64'd0);

    // Requester withdraws before the edge: no accept, pointer unchanged (still 3).
    @(negedge clk);
    valid0 = 4'b0001;
    #1;
    chk("forfeit_ready", 64'(ready0), 64'(onehot(0)));
    #2;
    valid0 = 4'b0000;
    @(negedge clk);
    #1;
    chk("forfeit_busy", 64'(busy0), 64'd0);
    run_txn("after_forfeit", 4'b1111, 32'd40, 32'd2, 3'd1, 3);

    // Reset pulse during EXEC discards the transaction and restarts the search at 0.
    @(negedge clk);
    valid0 = 4'b0100;
    set_ops0(32'h99, 32'h3, 3'd3);
    #1;
    chk("rstx_grant", 64'(ready0), 64'(onehot(2)));
    @(posedge clk);
    @(negedge clk);
    valid0 = 4'b0000;
    #1;
    chk("rstx_busy_exec", 64'(busy0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstx_alu_a", 64'(alua0), 64'd0);
    chk("rstx_alu_b", 64'(alub0), 64'd0);
    chk("rstx_alu_sel", 64'(alusel0), 64'd0);
    chk("rstx_rsp_valid", 64'(rspv0), 64'd0);
    chk("rstx_rsp_id", 64'(rspid0), 64'd0);
    chk("rstx_rsp_data", 64'(rspdata0), 64'd0);
    chk("rstx_busy", 64'(busy0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (rspv0) seen = 1'b1;
    end
    chk("rstx_no_rsp", 64'(seen), 64'd0);
    run_txn("rstx_next", 4'b1010, 32'd300, 32'd45, 3'd1, 1);

    // Registered ALU: EXEC lasts two cycles.
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      a1[k*32 +: 32] = 32'd9;
      b1[k*32 +: 32] = 32'd4;
      sel1[k*3 +: 3] = 3'b001;
    end
    valid1 = 4'b0100;
    #1;
    chk("lat1_grant", 64'(ready1), 64'(onehot(2)));
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      valid1 = 4'b0000;
      lat++;
      #1;
    end while (!rspv1 && lat < 10);
    chk("lat1_latency", 64'(lat), 64'd3);
    chk("lat1_id", 64'(rspid1), 64'd2);
    chk("lat1_data", 64'(rspdata1), 64'd5);
    @(negedge clk);
    #1;
    chk("lat1_idle", 64'(busy1), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
